// File: rtl/mmio_pwm_timer.sv
// mmio_pwm_timer: data-memory-mapped peripheral with four 8-bit PWM channels
// (led/red/green/blue, active-high) and free-running MICROS/MILLIS counters.
// Register window (16 bytes at BASE_ADDR): 0x0 DUTY, 0x4 MICROS, 0x8 MILLIS, 0xC CTRL.
// Optional build macro MMIO_TIMER_LOAD_EN makes MICROS/MILLIS writable with SW.

// One PWM channel: shadow duty loaded at period wrap, registered compare output.
module mmio_pwm_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] pcnt,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                en,
    output logic                out
);
    logic [PWM_BITS-1:0] shadow;

    // Shadow only follows DUTY at the period boundary so outputs never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            out    <= 1'b0;
        end else begin
            if (wrap) shadow <= duty;
            out <= en && (pcnt < shadow);
        end
    end
endmodule

module mmio_pwm_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0,
    parameter int          CLK_HZ    = 12_000_000,
    parameter int          PWM_BITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);
    localparam int NUM_LANES = 4;
    localparam int PRE_DIV   = CLK_HZ / 1_000_000;
    localparam int PRE_W     = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    logic [NUM_LANES-1:0][7:0] duty;
    logic                      pwm_en;
    logic [31:0]               micros, millis;
    logic [PRE_W-1:0]          pre;
    logic [9:0]                sub;
    logic [PWM_BITS-1:0]       pcnt;
    logic [NUM_LANES-1:0]      pwm_out;

    logic                      hit, acc_ok, st_ok;
    logic [1:0]                off, bo;
    logic [3:0]                mask;
    logic [NUM_LANES-1:0][7:0] wdata;
    logic [31:0]               rword, rshift, rdata;

    assign hit = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign off = dmem_address[3:2];
    assign bo  = dmem_address[1:0];

    // Access decode: alignment, byte-lane mask, replicated store data, load extend.
    always_comb begin
        acc_ok = 1'b0;
        st_ok  = 1'b0;
        mask   = 4'b0000;
        wdata  = dmem_data_in;
        rword  = 32'h0;
        rdata  = 32'h0;
        case (funct3)
            3'b000, 3'b100: acc_ok = hit;
            3'b001, 3'b101: acc_ok = hit && !bo[0];
            3'b010:         acc_ok = hit && (bo == 2'b00);
            default:        acc_ok = 1'b0;
        endcase
        case (funct3)
            3'b000: begin
                mask  = 4'b0001 << bo;
                wdata = {4{dmem_data_in[7:0]}};
            end
            3'b001: begin
                mask  = bo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{dmem_data_in[15:0]}};
            end
            3'b010: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        st_ok = acc_ok && dmem_wren && (mask != 4'b0000);
        case (off)
            2'd0:    rword = duty;
            2'd1:    rword = micros;
            2'd2:    rword = millis;
            default: rword = {31'h0, pwm_en};
        endcase
        rshift = rword >> {bo, 3'b000};
        case (funct3)
            3'b000:  rdata = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  rdata = {{16{rshift[15]}}, rshift[15:0]};
            3'b010:  rdata = rshift;
            3'b100:  rdata = {24'h0, rshift[7:0]};
            3'b101:  rdata = {16'h0, rshift[15:0]};
            default: rdata = 32'h0;
        endcase
        if (!acc_ok) rdata = 32'h0;
    end

    // Writable registers and the registered load path (old value on same-cycle write).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty          <= '0;
            pwm_en        <= 1'b0;
            dmem_data_out <= 32'h0;
        end else begin
            dmem_data_out <= rdata;
            if (st_ok && off == 2'd0) begin
                for (int i = 0; i < NUM_LANES; i++)
                    if (mask[i]) duty[i] <= wdata[i];
            end
            if (st_ok && off == 2'd3 && mask[0]) pwm_en <= wdata[0][0];
        end
    end

    logic us_tick, ms_tick, ld_us, ld_ms;
    assign us_tick = (pre == PRE_W'(PRE_DIV - 1));
    assign ms_tick = us_tick && (sub == 10'd999);
`ifdef MMIO_TIMER_LOAD_EN
    assign ld_us = st_ok && (funct3 == 3'b010) && (off == 2'd1);
    assign ld_ms = st_ok && (funct3 == 3'b010) && (off == 2'd2);
`else
    assign ld_us = 1'b0;
    assign ld_ms = 1'b0;
`endif

    // Timebase: prescaler -> MICROS, 0..999 sub-counter -> MILLIS; a load beats a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre    <= '0;
            sub    <= '0;
            micros <= 32'h0;
            millis <= 32'h0;
        end else begin
            if (ld_us) begin
                pre    <= '0;
                micros <= dmem_data_in;
            end else if (us_tick) begin
                pre    <= '0;
                micros <= micros + 32'd1;
            end else begin
                pre <= pre + PRE_W'(1);
            end
            if (ld_ms) begin
                sub    <= '0;
                millis <= dmem_data_in;
            end else if (us_tick) begin
                sub <= ms_tick ? 10'd0 : sub + 10'd1;
                if (ms_tick) millis <= millis + 32'd1;
            end
        end
    end

    // Free-running PWM period counter, shared by all channels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pcnt <= '0;
        else        pcnt <= pcnt + PWM_BITS'(1);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mmio_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
                .clk   (clk),
                .reset (reset),
                .pcnt  (pcnt),
                .wrap  (pcnt == '1),
                .duty  (duty[g][PWM_BITS-1:0]),
                .en    (pwm_en),
                .out   (pwm_out[g])
            );
        end
    endgenerate

    assign led   = pwm_out[0];
    assign red   = pwm_out[1];
    assign green = pwm_out[2];
    assign blue  = pwm_out[3];
endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Directed bench for mmio_pwm_timer: register access, PWM duty counts,
// timebase counts, alignment/miss handling and asynchronous reset.
module tb_mmio_pwm_timer;
    localparam logic [31:0] B = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
    logic        led, red, green, blue;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_led, n_red, n_green, n_blue;

    mmio_pwm_timer dut (
        .clk           (clk),
        .reset         (reset),
        .funct3        (funct3),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .led           (led),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a);
        funct3 = f3; dmem_address = a; dmem_wren = 1'b0;
        step();
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        funct3 = f3; dmem_address = a; dmem_data_in = d; dmem_wren = 1'b1;
        step();
        dmem_wren = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; dmem_wren = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [31:0] pwm4();
        return {28'h0, blue, green, red, led};
    endfunction

    initial begin
        reset = 1'b0; funct3 = 3'b010; dmem_wren = 1'b0;
        dmem_address = 32'h0; dmem_data_in = 32'h0;
        #2;
        check("rst_dout", dmem_data_out, 32'h0);
        check("rst_pwm", pwm4(), 32'h0);
        do_reset();

        // Reset values through the bus
        ld(3'b010, B + 32'h4); check("lw_micros_rst", dmem_data_out, 32'h0);
        ld(3'b010, B + 32'h8); check("lw_millis_rst", dmem_data_out, 32'h0);
        ld(3'b010, B + 32'hC); check("lw_ctrl_rst", dmem_data_out, 32'h0);
        check("pwm_idle", pwm4(), 32'h0);

        // PWM duty counts over two full periods
        st(3'b010, B, 32'h4080_FF00);
        st(3'b010, B + 32'hC, 32'h1);
        ld(3'b010, B + 32'hC); check("lw_ctrl_en", dmem_data_out, 32'h1);
        while (cyc % 256 != 0) step();
        n_led = 0; n_red = 0; n_green = 0; n_blue = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            n_led += int'(led); n_red += int'(red);
            n_green += int'(green); n_blue += int'(blue);
        end
        check("led_cnt", n_led, 0);
        check("red_cnt", n_red, 510);
        check("green_cnt", n_green, 256);
        check("blue_cnt", n_blue, 128);

        // CTRL: only bit0 sticks; disabling forces outputs low on the next edge
        st(3'b010, B + 32'hC, 32'hFFFF_FFFE);
        ld(3'b010, B + 32'hC); check("ctrl_off", dmem_data_out, 32'h0);
        check("pwm_forced_low", pwm4(), 32'h0);
        st(3'b000, B + 32'hC, 32'h0000_00FF);
        ld(3'b010, B + 32'hC); check("ctrl_sb_on", dmem_data_out, 32'h1);

        // Byte store, read-during-write, load extension
        st(3'b000, B + 32'h2, 32'h12); check("rdw_old", dmem_data_out, 32'hFFFF_FF80);
        ld(3'b010, B);          check("lw_duty_sb", dmem_data_out, 32'h4012_FF00);
        ld(3'b000, B + 32'h3);  check("lb_b3", dmem_data_out, 32'h0000_0040);
        ld(3'b000, B + 32'h1);  check("lb_b1", dmem_data_out, 32'hFFFF_FFFF);
        ld(3'b100, B + 32'h1);  check("lbu_b1", dmem_data_out, 32'h0000_00FF);
        ld(3'b001, B + 32'h2);  check("lh_h1", dmem_data_out, 32'h0000_4012);
        ld(3'b001, B);          check("lh_h0", dmem_data_out, 32'hFFFF_FF00);
        ld(3'b101, B);          check("lhu_h0", dmem_data_out, 32'h0000_FF00);

        // Misaligned, miss and unlisted funct3
        st(3'b001, B + 32'h1, 32'hAAAA);  check("sh_mis_rd", dmem_data_out, 32'h0);
        ld(3'b010, B);                    check("duty_after_sh", dmem_data_out, 32'h4012_FF00);
        st(3'b010, B + 32'h10, 32'hDEAD_BEEF); check("miss_rd", dmem_data_out, 32'h0);
        ld(3'b010, B);                    check("duty_after_miss", dmem_data_out, 32'h4012_FF00);
        ld(3'b011, B);                    check("bad_f3", dmem_data_out, 32'h0);
        ld(3'b010, B);
        ld(3'b010, B + 32'h2);            check("lw_mis", dmem_data_out, 32'h0);

        // Asynchronous reset mid-period with led duty 200
        st(3'b000, B, 32'hC8);
        step();
        while (cyc % 256 != 0) step();
        while (cyc % 256 != 10) step();
        check("led_hi_pre_rst", {31'h0, led}, 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_pwm", pwm4(), 32'h0);
        check("async_rst_dout", dmem_data_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; cyc = 0;
        ld(3'b010, B);         check("duty_after_rst", dmem_data_out, 32'h0);
        ld(3'b010, B + 32'hC); check("ctrl_after_rst", dmem_data_out, 32'h0);

        // MICROS write: loads only with the load option
        do_reset();
        st(3'b010, B + 32'h4, 32'hFFFF_FFFF);
        ld(3'b010, B + 32'h4);
`ifdef MMIO_TIMER_LOAD_EN
        check("micros_loaded", dmem_data_out, 32'hFFFF_FFFF);
`else
        check("micros_ro", dmem_data_out, 32'h0);
`endif
        while (cyc < 13) step();
        ld(3'b010, B + 32'h4);
`ifdef MMIO_TIMER_LOAD_EN
        check("micros_wrap", dmem_data_out, 32'h0);
`else
        check("micros_count", dmem_data_out, 32'h1);
`endif

        // Timebase over 12000 cycles at 12 MHz
        do_reset();
        funct3 = 3'b010; dmem_address = B + 32'h4;
        while (cyc < 12000) step();
        check("micros_999", dmem_data_out, 32'd999);
        step();
        check("micros_1000", dmem_data_out, 32'd1000);
        ld(3'b010, B + 32'h8); check("millis_1", dmem_data_out, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
